// File: rtl/pingpong_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_ram_if
// Brief    : Write/read handshake and data bundle for the ping-pong bank buffer.
// Revision : 1.0
// ============================================================================
interface pingpong_ram_if #(
    parameter int AW = 6,
    parameter int W  = 32
);
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [W-1:0]  i_wr_data;
    logic          i_wr_done;
    logic          o_wr_ready;
    logic          i_rd_en;
    logic [AW-1:0] i_rd_addr;
    logic          i_rd_done;
    logic          o_rd_ready;
    logic [W-1:0]  o_rd_data;
    logic          o_rd_valid;
    logic [1:0]    o_level;
    logic          o_wr_err;
    logic          o_rd_err;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_wr_done,
        output i_rd_en, i_rd_addr, i_rd_done,
        input  o_wr_ready, o_rd_ready, o_rd_data, o_rd_valid,
        input  o_level, o_wr_err, o_rd_err
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_wr_done,
        input  i_rd_en, i_rd_addr, i_rd_done,
        output o_wr_ready, o_rd_ready, o_rd_data, o_rd_valid,
        output o_level, o_wr_err, o_rd_err
    );
endinterface
`default_nettype wire

// File: rtl/pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_ram
// Brief    : Two-bank ping-pong RAM between FFT stages; writer fills one bank
//            while reader drains the other. Optional macro BITREV_RD_EN
//            bit-reverses the read address for FFT output reordering.
// Revision : 1.0
// ============================================================================
module pingpong_ram #(
    parameter int N  = 64,
    parameter int I  = 8,
    parameter int F  = 8,
    parameter int CH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pingpong_ram_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int W  = CH * (I + F);

    typedef enum logic [0:0] {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_t;

    bank_state_t      r_bank_state [2];
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_level;
    logic             r_wr_err;
    logic             r_rd_err;
    logic             r_rd_valid;
    logic [W-1:0]     r_rd_data;
    logic [W-1:0]     r_mem [2*N];

    logic             w_wr_ready;
    logic             w_rd_ready;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_wr_rel;
    logic             w_rd_rel;
    logic [AW-1:0]    w_rd_addr;

    assign w_wr_ready = (r_bank_state[r_wr_sel] == FREE);
    assign w_rd_ready = (r_bank_state[r_rd_sel] == FULL);
    assign w_wr_acc   = bus.i_wr_en   & w_wr_ready;
    assign w_rd_acc   = bus.i_rd_en   & w_rd_ready;
    assign w_wr_rel   = bus.i_wr_done & w_wr_ready;
    assign w_rd_rel   = bus.i_rd_done & w_rd_ready;

`ifdef BITREV_RD_EN
    generate
        for (genvar k = 0; k < AW; k++) begin : g_bitrev
            assign w_rd_addr[k] = bus.i_rd_addr[AW-1-k];
        end
    endgenerate
`else
    assign w_rd_addr = bus.i_rd_addr;
`endif

    // Storage carries no reset so it maps onto a single 2N-deep block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[{r_wr_sel, bus.i_wr_addr}] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_state[0] <= FREE;
            r_bank_state[1] <= FREE;
            r_wr_sel        <= 1'b0;
            r_rd_sel        <= 1'b0;
            r_level         <= 2'd0;
            r_wr_err        <= 1'b0;
            r_rd_err        <= 1'b0;
            r_rd_valid      <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_wr_err   <= (bus.i_wr_en | bus.i_wr_done) & ~w_wr_ready;
            r_rd_err   <= (bus.i_rd_en | bus.i_rd_done) & ~w_rd_ready;
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[{r_rd_sel, w_rd_addr}];
            end
            // When both release together they always own different banks.
            if (w_wr_rel) begin
                r_bank_state[r_wr_sel] <= FULL;
                r_wr_sel               <= ~r_wr_sel;
            end
            if (w_rd_rel) begin
                r_bank_state[r_rd_sel] <= FREE;
                r_rd_sel               <= ~r_rd_sel;
            end
            case ({w_wr_rel, w_rd_rel})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.o_wr_ready = w_wr_ready;
    assign bus.o_rd_ready = w_rd_ready;
    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_level    = r_level;
    assign bus.o_wr_err   = r_wr_err;
    assign bus.o_rd_err   = r_rd_err;
endmodule
`default_nettype wire
